vx_alu_dotn: RTL and testbench
==============================

// Module: vx_alu_dotn
// PURPOSE
//  Parametrised packed dot-product processing element for the ALU execute block; successor to the fixed int8 dot unit.
//  Per lane: rd = c + sum(a[i]*b[i]) over packed sub-elements. Sub-elements are 4x8-bit or 2x16-bit, signed or unsigned.
//  Optional saturation. 3-stage elastic pipeline with valid/ready handshake.
//  Sits behind the PE switch as one of PE_COUNT engines; the request tag passes through unchanged for commit.
// PARAMETERS
//  NUM_LANES   4   lanes processed in parallel per request
//  XLEN        32  operand/result width per lane (fixed 32 in this version)
//  TAG_W       16  sideband width (uuid/wid/tmask/PC/rd/pid...), opaque
//  ACC_W       36  internal accumulator width; must be >= XLEN+3
// PORTS
//  clk          in   1               clock
//  reset        in   1               synchronous, active-high
//  valid_in     in   1               request valid
//  ready_in     out  1               request accepted when valid_in & ready_in
//  mode_in      in   2               00 s8x4, 01 u8x4, 10 s16x2, 11 u16x2
//  sat_in       in   1               1 = saturate result to 32-bit range of mode signedness
//  acc_in       in   1               1 = add c operand; 0 = treat c as 0
//  a_in         in   NUM_LANES*XLEN  packed multiplicand per lane
//  b_in         in   NUM_LANES*XLEN  packed multiplier per lane
//  c_in         in   NUM_LANES*XLEN  accumulator operand per lane
//  tag_in       in   TAG_W           sideband, returned with result
//  valid_out    out  1               result valid
//  ready_out    in   1               result consumed when valid_out & ready_out
//  data_out     out  NUM_LANES*XLEN  per-lane result
//  tag_out      out  TAG_W           sideband of this result
// BEHAVIOUR
//  Reset: all stage valid bits = 0; valid_out = 0; data_out/tag_out = 0. ready_in = 1 one cycle after reset deasserts.
//  Pipeline: S0 latch operands+mode+tag; S1 sub-products (sign/zero-extended per mode); S2 adder tree + c, saturate -> output reg.
//  Latency: exactly 3 cycles from accept to valid_out when unstalled; throughput 1 request/cycle.
//  Elastic: stage k advances if stage k empty or stage k+1 advances; output advances if !valid_out | ready_out.
//  Bubbles collapse; ready_in = S0 can advance (combinational from ready_out allowed; no comb path valid_in -> valid_out).
//  Stall: while valid_out & !ready_out, data_out/tag_out hold stable; up to 3 requests held, no loss/duplication.
//  Order: strictly in order; tag_out always paired with its own data.
//  Arithmetic: products and sum in ACC_W signed; c sign-extended in signed modes, zero-extended in unsigned.
//   sat=0: data_out = sum[31:0] (wrap). sat=1 signed: clamp to [0x80000000,0x7FFFFFFF].
//   sat=1 unsigned: clamp to 0xFFFFFFFF (sum never negative).
//  Lanes independent; no cross-lane interaction. Mode/sat/acc sampled per request, may change every cycle.
//  Simultaneous accept and output handshake in same cycle: both occur, occupancy unchanged.
//  Reset mid-operation: all in-flight requests discarded, valid_out = 0 next cycle; nothing emitted later.
//  Illegal: none; all 2-bit modes defined. X on data when valid=0 must not propagate to valid_out.
// TESTING
//  s8x4 a=0x01020304 b=0x01010101 c=0 acc=0 -> data=0x0000000A after 3 cycles, tag echoed
//  s8x4 a=0xFFFFFFFF b=0x01010101 acc=1 c=0x00000010 -> 0x0000000C; u8x4 same a/b, c=0 -> 0x000003FC
//  u16x2 a=b=0xFFFFFFFF c=0: sat=0 -> 0xFFFC0002; sat=1 -> 0xFFFFFFFF
//  s16x2 a=b=0x80008000 c=0x7FFFFFFF acc=1 sat=1 -> 0x7FFFFFFF; sat=0 -> 0x7FFFFFFF+0x80000000 wraps to 0xFFFFFFFF
//  Back-to-back 8 requests, ready_out low cycles 4-9: ready_in drops after 3 held, all 8 out in order, data stable while stalled
//  Reset asserted with 3 in flight -> valid_out=0 next cycle, no stale result after reset release; random compare vs model

Source files
------------

// File: rtl/vx_alu_dotn_if.sv
// Request/response bundle for the packed dot-product engine.
// master = requester/consumer side, slave = the engine.
interface vx_alu_dotn_if #(
    parameter int NUM_LANES = 4,
    parameter int XLEN      = 32,
    parameter int TAG_W     = 16
) ();
    logic                      valid_in;
    logic                      ready_in;
    logic [1:0]                mode_in;
    logic                      sat_in;
    logic                      acc_in;
    logic [NUM_LANES*XLEN-1:0] a_in;
    logic [NUM_LANES*XLEN-1:0] b_in;
    logic [NUM_LANES*XLEN-1:0] c_in;
    logic [TAG_W-1:0]          tag_in;
    logic                      valid_out;
    logic                      ready_out;
    logic [NUM_LANES*XLEN-1:0] data_out;
    logic [TAG_W-1:0]          tag_out;

    modport master (
        output valid_in, mode_in, sat_in, acc_in, a_in, b_in, c_in, tag_in, ready_out,
        input  ready_in, valid_out, data_out, tag_out
    );

    modport slave (
        input  valid_in, mode_in, sat_in, acc_in, a_in, b_in, c_in, tag_in, ready_out,
        output ready_in, valid_out, data_out, tag_out
    );
endinterface

// File: rtl/vx_alu_dotn.sv
// Packed dot-product engine: rd = c + sum(a[i]*b[i]) per lane, 4x8 or 2x16 sub-elements,
// optional saturation, three-stage elastic pipeline (operand latch, sub-products, sum/saturate).
module vx_alu_dotn #(
    parameter int NUM_LANES = 4,
    parameter int XLEN      = 32,
    parameter int TAG_W     = 16,
    parameter int ACC_W     = 36
) (
    input logic         clk,
    input logic         reset,
    vx_alu_dotn_if.slave bus
);
    localparam int NSUB = 4;
    localparam int DW   = NUM_LANES * XLEN;

    typedef logic signed [ACC_W-1:0] acc_t;

    // Sub-element k of a word, widened to 17 bits signed; x2 modes yield zero for k >= 2.
    function automatic logic signed [16:0] sub_ext(input logic [31:0] w, input logic [1:0] mode,
                                                   input logic [1:0] k);
        logic [15:0] e;
        logic        s;
        if (mode[1]) begin
            e = k[0] ? w[31:16] : w[15:0];
            if (k[1]) e = '0;
            s = !mode[0] && e[15];
        end else begin
            e = {8'd0, w[{k, 3'b000} +: 8]};
            s = !mode[0] && e[7];
            if (s) e[15:8] = 8'hFF;
        end
        return {s, e};
    endfunction

    function automatic acc_t sub_prod(input logic [31:0] a, input logic [31:0] b,
                                      input logic [1:0] mode, input logic [1:0] k);
        logic signed [16:0] ea;
        logic signed [16:0] eb;
        logic signed [33:0] p;
        ea = sub_ext(a, mode, k);
        eb = sub_ext(b, mode, k);
        p  = ea * eb;
        return {{(ACC_W-34){p[33]}}, p};
    endfunction

    function automatic acc_t c_ext(input logic [31:0] c, input logic acc, input logic uns);
        if (!acc) return '0;
        return uns ? {{(ACC_W-32){1'b0}}, c} : {{(ACC_W-32){c[31]}}, c};
    endfunction

    // Unsigned sums are never negative, so only the upper bound needs clamping there.
    function automatic logic [31:0] sat_res(input acc_t s, input logic sat, input logic uns);
        logic [ACC_W-32:0] hi;
        hi = s[ACC_W-1:31];
        if (!sat) return s[31:0];
        if (uns) return (|hi[ACC_W-32:1]) ? 32'hFFFF_FFFF : s[31:0];
        if ((&hi) || !(|hi)) return s[31:0];
        return hi[ACC_W-32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    endfunction

    logic r_vld_p0, r_vld_p1, r_vld_p2;
    logic w_adv0, w_adv1, w_adv2, w_take;

    logic [1:0]       r_mode_p0;
    logic             r_sat_p0, r_acc_p0;
    logic [DW-1:0]    r_a_p0, r_b_p0, r_c_p0;
    logic [TAG_W-1:0] r_tag_p0;

    acc_t             w_prod_p0 [NUM_LANES][NSUB];
    acc_t             w_c_p0    [NUM_LANES];
    acc_t             r_prod_p1 [NUM_LANES][NSUB];
    acc_t             r_c_p1    [NUM_LANES];
    logic             r_sat_p1, r_uns_p1;
    logic [TAG_W-1:0] r_tag_p1;

    logic [DW-1:0]    w_res_p1;
    logic [DW-1:0]    r_data_p2;
    logic [TAG_W-1:0] r_tag_p2;

    assign w_adv2       = !r_vld_p2 || bus.ready_out;
    assign w_adv1       = !r_vld_p1 || w_adv2;
    assign w_adv0       = !r_vld_p0 || w_adv1;
    assign bus.ready_in = w_adv0 && !reset;
    assign w_take       = bus.valid_in && bus.ready_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else begin
            if (w_adv0) r_vld_p0 <= w_take;
            if (w_adv1) r_vld_p1 <= r_vld_p0;
            if (w_adv2) r_vld_p2 <= r_vld_p1;
        end
    end

    // Stage 0: operand latch
    always_ff @(posedge clk) begin
        if (w_take) begin
            r_mode_p0 <= bus.mode_in;
            r_sat_p0  <= bus.sat_in;
            r_acc_p0  <= bus.acc_in;
            r_a_p0    <= bus.a_in;
            r_b_p0    <= bus.b_in;
            r_c_p0    <= bus.c_in;
            r_tag_p0  <= bus.tag_in;
        end
    end

    // Stage 1: per-lane sub-products and extended c
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            w_c_p0[l] = c_ext(r_c_p0[l*XLEN +: 32], r_acc_p0, r_mode_p0[0]);
            for (int k = 0; k < NSUB; k++) begin
                w_prod_p0[l][k] = sub_prod(r_a_p0[l*XLEN +: 32], r_b_p0[l*XLEN +: 32],
                                           r_mode_p0, 2'(k));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv1 && r_vld_p0) begin
            r_prod_p1 <= w_prod_p0;
            r_c_p1    <= w_c_p0;
            r_sat_p1  <= r_sat_p0;
            r_uns_p1  <= r_mode_p0[0];
            r_tag_p1  <= r_tag_p0;
        end
    end

    // Stage 2: adder tree plus c, saturate, output register
    always_comb begin
        w_res_p1 = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            w_res_p1[l*XLEN +: 32] = sat_res(r_c_p1[l] + r_prod_p1[l][0] + r_prod_p1[l][1]
                                             + r_prod_p1[l][2] + r_prod_p1[l][3],
                                             r_sat_p1, r_uns_p1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_p2 <= '0;
            r_tag_p2  <= '0;
        end else if (w_adv2 && r_vld_p1) begin
            r_data_p2 <= w_res_p1;
            r_tag_p2  <= r_tag_p1;
        end
    end

    assign bus.valid_out = r_vld_p2;
    assign bus.data_out  = r_data_p2;
    assign bus.tag_out   = r_tag_p2;
endmodule

// File: tb/tb_vx_alu_dotn.sv
// Bench for vx_alu_dotn: directed vectors, back-pressure, reset flush and random traffic
// compared against an arithmetic reference model through an in-order scoreboard.
module tb_vx_alu_dotn;
    localparam int NL = 4;
    localparam int XL = 32;
    localparam int TW = 16;
    localparam int AW = 36;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vx_alu_dotn_if #(.NUM_LANES(NL), .XLEN(XL), .TAG_W(TW)) bus ();
    vx_alu_dotn #(.NUM_LANES(NL), .XLEN(XL), .TAG_W(TW), .ACC_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]       mode;
        logic             sat;
        logic             acc;
        logic [NL*XL-1:0] a, b, c;
        logic [TW-1:0]    tag;
        logic             has_k;
        logic [31:0]      k;
    } req_t;

    typedef struct {
        logic [NL*XL-1:0] data;
        logic [TW-1:0]    tag;
        int               acc_cyc;
        logic             has_k;
        logic [31:0]      k;
    } exp_t;

    req_t pend[$];
    exp_t expq[$];
    int   n_chk = 0, n_err = 0, cyc = 0, max_occ = 0, n_out = 0;
    logic rst_drv = 1'b1, rdy_v = 1'b1, rnd_rdy = 1'b0, rnd_gap = 1'b0, chk_lat = 1'b0;
    logic prev_stall = 1'b0, saw_drop = 1'b0;
    logic [NL*XL-1:0] prev_data;
    logic [TW-1:0]    prev_tag;
    logic [TW-1:0]    tag_ctr = '0;

    task automatic chk_val(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One lane: c (extended by mode signedness) plus the sum of element products, then optional clamp.
    function automatic logic [31:0] ref_lane(input logic [1:0] mode, input logic sat, input logic acc,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c);
        longint s, ea, eb;
        logic [31:0] ta, tb;
        logic [15:0] a16, b16;
        logic [7:0]  a8, b8;
        s  = 0;
        ta = a;
        tb = b;
        if (acc) s = mode[0] ? longint'(c) : longint'($signed(c));
        for (int k = 0; k < (mode[1] ? 2 : 4); k++) begin
            if (mode[1]) begin
                a16 = ta[15:0]; b16 = tb[15:0];
                ea  = mode[0] ? longint'(a16) : longint'($signed(a16));
                eb  = mode[0] ? longint'(b16) : longint'($signed(b16));
                ta  = ta >> 16; tb = tb >> 16;
            end else begin
                a8 = ta[7:0]; b8 = tb[7:0];
                ea = mode[0] ? longint'(a8) : longint'($signed(a8));
                eb = mode[0] ? longint'(b8) : longint'($signed(b8));
                ta = ta >> 8; tb = tb >> 8;
            end
            s += ea * eb;
        end
        if (sat) begin
            if (mode[0]) begin
                if (s > 64'sd4294967295) s = 64'sd4294967295;
            end else begin
                if (s > 64'sd2147483647) s = 64'sd2147483647;
                if (s < -64'sd2147483648) s = -64'sd2147483648;
            end
        end
        return s[31:0];
    endfunction

    function automatic logic [NL*XL-1:0] ref_req(input req_t r);
        logic [NL*XL-1:0] o;
        o = '0;
        for (int l = 0; l < NL; l++)
            o[l*XL +: XL] = ref_lane(r.mode, r.sat, r.acc, r.a[l*XL +: XL], r.b[l*XL +: XL],
                                     r.c[l*XL +: XL]);
        return o;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_8000;
            3: return 32'h7FFF_7FFF;
            4: return 32'h8080_8080;
            default: return $urandom;
        endcase
    endfunction

    task automatic push_req(input logic [1:0] mode, input logic sat, input logic acc,
                            input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] c0,
                            input logic has_k, input logic [31:0] k);
        req_t r;
        r.mode = mode; r.sat = sat; r.acc = acc;
        for (int l = 1; l < NL; l++) begin
            r.a[l*XL +: XL] = pick();
            r.b[l*XL +: XL] = pick();
            r.c[l*XL +: XL] = pick();
        end
        r.a[XL-1:0] = a0; r.b[XL-1:0] = b0; r.c[XL-1:0] = c0;
        r.tag   = tag_ctr;
        tag_ctr = tag_ctr + 1'b1;
        r.has_k = has_k;
        r.k     = k;
        pend.push_back(r);
    endtask

    task automatic push_rand();
        push_req(2'($urandom), 1'($urandom), 1'($urandom), pick(), pick(), pick(), 1'b0, 32'd0);
    endtask

    task automatic step();
        req_t r;
        exp_t e;
        logic pres;
        @(negedge clk);
        reset = rst_drv;
        if (rnd_rdy) rdy_v = ($urandom_range(0, 9) < 7);
        bus.ready_out = rdy_v;
        pres = (pend.size() > 0) && !rst_drv && (!rnd_gap || $urandom_range(0, 3) != 0);
        bus.valid_in = pres;
        if (pres) begin
            r = pend[0];
            bus.mode_in = r.mode; bus.sat_in = r.sat; bus.acc_in = r.acc;
            bus.a_in = r.a; bus.b_in = r.b; bus.c_in = r.c; bus.tag_in = r.tag;
        end else begin
            bus.mode_in = 2'($urandom); bus.sat_in = 1'($urandom); bus.acc_in = 1'($urandom);
            bus.a_in = {$urandom, $urandom, $urandom, $urandom};
            bus.b_in = {$urandom, $urandom, $urandom, $urandom};
            bus.c_in = {$urandom, $urandom, $urandom, $urandom};
            bus.tag_in = 16'($urandom);
        end
        #1;
        if (rst_drv) begin
            expq.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk_val("stall_hold", {bus.valid_out, bus.tag_out, bus.data_out},
                        {1'b1, prev_tag, prev_data});
            if (bus.valid_out && bus.ready_out) begin
                n_out++;
                chk_val("out_expected", expq.size() > 0, 1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk_val("result", {bus.tag_out, bus.data_out}, {e.tag, e.data});
                    if (e.has_k)
                        chk_val($sformatf("vector_t%0d", e.tag), bus.data_out[31:0], e.k);
                    if (chk_lat) chk_val("latency", cyc - e.acc_cyc, 3);
                end
            end
            if (pres && !bus.ready_in) saw_drop = 1'b1;
            if (pres && bus.ready_in) begin
                e.data = ref_req(r); e.tag = r.tag; e.acc_cyc = cyc;
                e.has_k = r.has_k; e.k = r.k;
                expq.push_back(e);
                void'(pend.pop_front());
            end
            if (expq.size() > max_occ) max_occ = expq.size();
            prev_stall = bus.valid_out && !bus.ready_out;
            prev_data  = bus.data_out;
            prev_tag   = bus.tag_out;
        end
        cyc++;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (pend.size() > 0 || expq.size() > 0); i++) step();
        chk_val("drain_left", pend.size() + expq.size(), 0);
    endtask

    initial begin
        int outs0;
        bus.valid_in = 1'b0; bus.ready_out = 1'b1;
        bus.mode_in = '0; bus.sat_in = 1'b0; bus.acc_in = 1'b0;
        bus.a_in = '0; bus.b_in = '0; bus.c_in = '0; bus.tag_in = '0;

        repeat (3) step();
        rst_drv = 1'b0;
        step();
        chk_val("rst_valid_out", bus.valid_out, 0);
        chk_val("rst_data_out", bus.data_out, 0);
        chk_val("rst_tag_out", bus.tag_out, 0);
        chk_val("rst_ready_in", bus.ready_in, 1);

        chk_lat = 1'b1;
        push_req(2'b00, 0, 0, 32'h0102_0304, 32'h0101_0101, 32'h0000_0000, 1, 32'h0000_000A);
        push_req(2'b00, 0, 1, 32'hFFFF_FFFF, 32'h0101_0101, 32'h0000_0010, 1, 32'h0000_000C);
        push_req(2'b01, 0, 1, 32'hFFFF_FFFF, 32'h0101_0101, 32'h0000_0000, 1, 32'h0000_03FC);
        push_req(2'b11, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1, 32'hFFFC_0002);
        push_req(2'b11, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1, 32'hFFFF_FFFF);
        push_req(2'b10, 1, 1, 32'h8000_8000, 32'h8000_8000, 32'h7FFF_FFFF, 1, 32'h7FFF_FFFF);
        push_req(2'b10, 0, 1, 32'h8000_8000, 32'h8000_8000, 32'h7FFF_FFFF, 1, 32'hFFFF_FFFF);
        push_req(2'b10, 1, 1, 32'h8000_8000, 32'h7FFF_7FFF, 32'h8000_0000, 1, 32'h8000_0000);
        push_req(2'b00, 0, 0, 32'h0102_0304, 32'h0101_0101, 32'hDEAD_BEEF, 1, 32'h0000_000A);
        drain(100);
        chk_lat = 1'b0;

        // back-to-back burst with the consumer stalled for six cycles
        max_occ = 0; saw_drop = 1'b0;
        repeat (8) push_rand();
        for (int k = 0; k < 20; k++) begin
            rdy_v = !(k >= 4 && k <= 9);
            step();
        end
        rdy_v = 1'b1;
        drain(100);
        chk_val("b2b_ready_drop", saw_drop, 1);
        chk_val("b2b_max_occ", max_occ, 3);

        // flush three held requests with reset
        rdy_v = 1'b0;
        repeat (3) push_rand();
        for (int i = 0; i < 20 && pend.size() > 0; i++) step();
        repeat (3) step();
        chk_val("pre_rst_valid", bus.valid_out, 1);
        rst_drv = 1'b1;
        step();
        rst_drv = 1'b0;
        step();
        chk_val("rst_mid_valid_out", bus.valid_out, 0);
        rdy_v = 1'b1;
        outs0 = n_out;
        repeat (10) step();
        chk_val("post_rst_quiet", n_out - outs0, 0);

        // random traffic with random back-pressure and input gaps
        rnd_rdy = 1'b1; rnd_gap = 1'b1;
        repeat (400) push_rand();
        drain(6000);
        rnd_rdy = 1'b0; rnd_gap = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
